seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the longest detectable pattern in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in  input  1  serial data bit.
REQ-006 SHALL have port in_valid  input  1  qualifies in; the bit is consumed only when high.
REQ-007 SHALL have port cfg_load  input  1  single-cycle strobe that latches the cfg_* inputs.
REQ-008 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit expected, bit 0 the last.
REQ-009 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-010 SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 SHALL have port Q  output  1  registered match pulse.
REQ-013 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 SHALL have port state  output  2  FSM state (IDLE=0, FILL=1, RUN=2).
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse flagging a rejected cfg_load.

Function
REQ-016 SHALL hold history hist[MAX_LEN-1:0]; on each accepted bit it shifts left with in entering bit 0.
REQ-017 SHALL keep fill, the number of valid history bits, saturating at the active length.
REQ-018 SHALL implement IDLE -> FILL on a valid cfg_load, FILL -> RUN when fill reaches len, RUN -> FILL after a match in non-overlap mode, and any state -> FILL on a valid cfg_load.
REQ-019 SHALL in IDLE ignore in_valid and never assert Q.
REQ-020 SHALL accept cfg_load only if 2 <= cfg_len <= MAX_LEN; on accept it latches pattern, length and overlap mode and clears hist and fill.
REQ-021 SHALL on a rejected cfg_load pulse cfg_err the following cycle and leave state and configuration unchanged.
REQ-022 SHALL give cfg_load priority over in_valid in the same cycle, discarding that data bit.
REQ-023 SHALL detect a match when an accepted bit makes the low len bits of the shifted history equal the low len bits of the pattern with fill >= len; bits above len are ignored.
REQ-024 SHALL assert Q for exactly one cycle, in the cycle after the completing bit is accepted (latency 1); Q is low in all other cycles, including cycles where in_valid is low.
REQ-025 SHALL in overlap mode leave hist and fill untouched after a match, so a trailing prefix can complete the next match.
REQ-026 SHALL in non-overlap mode zero fill after a match, so the next match needs len fresh bits.
REQ-027 SHALL increment match_cnt on each match and hold it at 2^CNT_W-1 once saturated.
REQ-028 SHALL, when cnt_clr and a match occur in the same cycle, load match_cnt with 1.

Reset
REQ-029 SHALL on rst_n low immediately force state=IDLE, Q=0, match_cnt=0, cfg_err=0, hist=0, fill=0, pattern=0, len=0 and overlap=0.
REQ-030 SHALL on a reset asserted mid-stream discard any partial match; after deassertion a cfg_load is needed before any detection.

Structure
REQ-031 SHALL place the state enum (IDLE/FILL/RUN) and the MAX_LEN legal-range constants in a shared package seq_detect_pkg.
REQ-032 SHALL implement the saturating counter with clear as sub-module sat_counter (parameter W; inputs inc and clr).

Verification
REQ-033 SHALL cover overlap mode: load 7'b1011101, len 7, overlap 1, then stream 1011101011101 -> Q pulses after bits 7 and 13, match_cnt=2.
REQ-034 SHALL cover non-overlap mode: same stream with overlap 0 -> one Q pulse after bit 7, match_cnt=1, state returns to FILL.
REQ-035 SHALL cover an invalid length: cfg_load with cfg_len=0 or MAX_LEN+1 -> cfg_err pulses once, state unchanged, and a subsequent stream matches against the previous pattern.
REQ-036 SHALL cover a gapped stream and a colliding load: in_valid low between bits of 1011 (len 4) -> a single Q one cycle after the last valid bit; cfg_load in the same cycle as in_valid -> that bit is discarded and fill=0.
REQ-037 SHALL cover saturation and clear: with CNT_W=2, produce 5 matches -> match_cnt holds at 3; cnt_clr together with a match -> match_cnt=1.
REQ-038 SHALL cover reset mid-match: rst_n low after 6 of 7 pattern bits -> Q=0, state=IDLE, and the 7th bit after release gives no Q.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parameterised serial pattern detector.
package seq_detect_pkg;

    // Detector FSM states; encodings are visible on the state output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Legal range for MAX_LEN and for a loaded pattern length.
    localparam int unsigned MIN_LEN       = 2;
    localparam int unsigned MAX_LEN_LIMIT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count register: clear wins over hold, saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap control and match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in,
    input  logic                         in_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         Q,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [1:0]                   state,
    output logic                         cfg_err
);

    localparam int unsigned LW = $clog2(MAX_LEN+1);

    state_t             st, st_n;
    logic [MAX_LEN-1:0] hist, hist_n;
    logic [MAX_LEN-1:0] pat, pat_n;
    logic [LW-1:0]      fill, fill_n;
    logic [LW-1:0]      len, len_n;
    logic               ovl, ovl_n;
    logic               match;
    logic               err_n;
    logic               cfg_ok;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      fill_inc;

    assign cfg_ok = (cfg_len >= LW'(MIN_LEN)) && (cfg_len <= LW'(MAX_LEN));
    // Shift written arithmetically so every history bit feeds the expression.
    assign shifted  = (hist << 1) | {{(MAX_LEN-1){1'b0}}, in};
    // Low len bits set; len == MAX_LEN shifts everything out, giving all ones.
    assign mask     = ~({MAX_LEN{1'b1}} << len);
    assign fill_inc = (fill < len) ? fill + 1'b1 : fill;

    // Next-state, configuration latching and match detection.
    always_comb begin
        st_n   = st;
        hist_n = hist;
        fill_n = fill;
        pat_n  = pat;
        len_n  = len;
        ovl_n  = ovl;
        match  = 1'b0;
        err_n  = 1'b0;
        if (cfg_load) begin
            // A load always swallows a coincident data bit, accepted or not.
            if (cfg_ok) begin
                pat_n  = cfg_pattern;
                len_n  = cfg_len;
                ovl_n  = cfg_overlap;
                hist_n = '0;
                fill_n = '0;
                st_n   = FILL;
            end else begin
                err_n = 1'b1;
            end
        end else if (in_valid && (st != IDLE)) begin
            hist_n = shifted;
            fill_n = fill_inc;
            match  = (fill_inc >= len) && (((shifted ^ pat) & mask) == '0);
            case (st)
                FILL, RUN: begin
                    if (match && !ovl) begin
                        fill_n = '0;
                        st_n   = FILL;
                    end else if (fill_inc == len) begin
                        st_n = RUN;
                    end
                end
                default: st_n = IDLE;
            endcase
        end
    end

    // State, history, configuration and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            hist    <= '0;
            fill    <= '0;
            pat     <= '0;
            len     <= '0;
            ovl     <= 1'b0;
            Q       <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            st      <= st_n;
            hist    <= hist_n;
            fill    <= fill_n;
            pat     <= pat_n;
            len     <= len_n;
            ovl     <= ovl_n;
            Q       <= match;
            cfg_err <= err_n;
        end
    end

    assign state = st;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomized checks of seq_detect_param against a bit-queue reference model.
module tb_seq_detect_param;

    localparam int ML   = 16;
    localparam int CW   = 2;
    localparam int LW   = $clog2(ML+1);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in = 1'b0;
    logic          in_valid = 1'b0;
    logic          cfg_load = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          Q;
    logic [CW-1:0] match_cnt;
    logic [1:0]    state;
    logic          cfg_err;

    seq_detect_param #(.MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .Q           (Q),
        .match_cnt   (match_cnt),
        .state       (state),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int qseen    = 0;

    // Reference model: accepted bits since the last load / non-overlap match.
    bit            m_act;
    logic [ML-1:0] m_pat;
    int            m_len;
    bit            m_ovl;
    bit            m_bits[$];
    int            m_cnt;
    bit            e_q;
    bit            e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_state();
        if (!m_act) return 0;
        return (m_bits.size() >= m_len) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_act = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_bits.delete();
        m_cnt = 0; e_q = 0; e_err = 0;
    endtask

    // Apply one clock edge's worth of input to the model.
    task automatic model_edge();
        bit hit;
        hit = 0; e_q = 0; e_err = 0;
        if (cfg_load) begin
            if (cfg_len >= 2 && int'(cfg_len) <= ML) begin
                m_act = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
                m_ovl = cfg_overlap; m_bits.delete();
            end else begin
                e_err = 1;
            end
        end else if (in_valid && m_act) begin
            m_bits.push_back(in);
            if (m_bits.size() > m_len) void'(m_bits.pop_front());
            if (m_bits.size() == m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[i] != m_pat[m_len-1-i]) hit = 0;
            end
            if (hit) begin
                e_q = 1;
                if (!m_ovl) m_bits.delete();
            end
        end
        if (cnt_clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic step(input logic b, input logic v, input logic ld, input logic [ML-1:0] p,
                        input logic [LW-1:0] l, input logic o, input logic c);
        in = b; in_valid = v; cfg_load = ld; cfg_pattern = p; cfg_len = l;
        cfg_overlap = o; cnt_clr = c;
        @(posedge clk);
        model_edge();
        #1;
        chk("q", 32'(Q), 32'(e_q));
        chk("cnt", 32'(match_cnt), 32'(m_cnt));
        chk("state", 32'(state), 32'(m_state()));
        chk("err", 32'(cfg_err), 32'(e_err));
        if (Q) qseen++;
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Overlapping matches.
        load(16'b1011101, 5'd7, 1'b1);
        qseen = 0;
        send(32'b1011101011101, 13);
        chk("ovl_pulses", 32'(qseen), 32'd2);
        chk("ovl_cnt", 32'(match_cnt), 32'd2);

        // Non-overlapping: same stream, one match, back to FILL.
        clr();
        load(16'b1011101, 5'd7, 1'b0);
        qseen = 0;
        send(32'b1011101011101, 13);
        chk("novl_pulses", 32'(qseen), 32'd1);
        chk("novl_cnt", 32'(match_cnt), 32'd1);
        chk("novl_state", 32'(state), 32'd1);

        // Rejected lengths keep the old pattern.
        load(16'hFFFF, 5'd0, 1'b1);
        chk("err0", 32'(cfg_err), 32'd1);
        idle();
        chk("err0_once", 32'(cfg_err), 32'd0);
        load(16'hFFFF, 5'd17, 1'b1);
        chk("err17", 32'(cfg_err), 32'd1);
        chk("err17_state", 32'(state), 32'd1);
        qseen = 0;
        send(32'b1011101, 7);
        chk("old_pat_pulses", 32'(qseen), 32'd1);

        // Gapped stream of 1011.
        load(16'b1011, 5'd4, 1'b0);
        qseen = 0;
        send(32'b1, 1); idle();
        send(32'b0, 1); idle(); idle();
        send(32'b1, 1); idle();
        chk("gap_noq_yet", 32'(qseen), 32'd0);
        send(32'b1, 1);
        chk("gap_q", 32'(Q), 32'd1);
        idle();
        chk("gap_q_single", 32'(Q), 32'd0);

        // Load colliding with a valid bit: the bit is dropped.
        qseen = 0;
        step(1'b1, 1'b1, 1'b1, 16'b1011, 5'd4, 1'b0, 1'b0);
        send(32'b011, 3);
        chk("collide_noq", 32'(qseen), 32'd0);
        chk("collide_fill", 32'(state), 32'd1);

        // Saturation and clear-with-match.
        clr();
        load(16'b11, 5'd2, 1'b1);
        send(32'b111111, 6);
        chk("sat_cnt", 32'(match_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("clr_match_cnt", 32'(match_cnt), 32'd1);

        // Reset after 6 of 7 pattern bits.
        load(16'b1011101, 5'd7, 1'b1);
        send(32'b101110, 6);
        do_reset();
        qseen = 0;
        send(32'b1, 1);
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_noq", 32'(qseen), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            logic          rb, rv, rl, ro, rc;
            logic [ML-1:0] rp;
            logic [LW-1:0] rlen;
            if ($urandom_range(0, 499) == 0) do_reset();
            rl   = ($urandom_range(0, 39) == 0);
            rlen = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 17)) : LW'($urandom_range(2, 4));
            rp   = ML'($urandom);
            ro   = 1'($urandom);
            rb   = 1'($urandom);
            rv   = ($urandom_range(0, 9) < 7);
            rc   = ($urandom_range(0, 49) == 0);
            if (k == 0) rl = 1'b1;
            step(rb, rv, rl, rp, rlen, ro, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
